// File: rtl/arbiter_4_way_16.sv
`default_nettype none
// ============================================================================
// Module   : arbiter_4_way_16
// Purpose  : Four-channel round-robin arbiter with a registered, ready/valid
//            output stage. One word per cycle is taken from the highest
//            priority requesting channel, where priority rotates so that the
//            channel after the most recently granted one is searched first.
//
// Ports    : clk        in   1      rising-edge clock
//            reset_n    in   1      asynchronous active-low reset
//            a,b,c,d    in   WIDTH  channel 0..3 data
//            in_valid   in   4      per-channel request (bit i = channel i)
//            in_ready   out  4      per-channel accept strobe (combinational)
//            out        out  WIDTH  registered data of the granted channel
//            select     out  2      registered index of the channel in out
//            out_valid  out  1      out/select hold an undelivered word
//            out_ready  in   1      consumer accepts out this cycle
//
// Revision : 1.0  initial release
// ============================================================================
module arbiter_4_way_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       select,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [1:0] C_LAST_RESET = 2'd3;

    // Reset synchronizer: assertion reaches the state flops immediately,
    // release is retimed to clk so every flop leaves reset on the same edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Pointer to the most recently granted channel. Resets to 3 so that
    // channel 0 is first in the search order.
    logic [1:0] r_last;

    logic             w_load;
    logic             w_any;
    logic             w_take;
    logic [1:0]       w_grant;
    logic [WIDTH-1:0] w_grant_data;

    assign w_load = !out_valid || out_ready;
    assign w_any  = |in_valid;
    // in_ready is only ever raised on a requesting channel, so a raised
    // strobe always completes an input transfer.
    assign w_take = w_load && w_any && w_rst_n;

    // Search order last+1, last+2, last+3, last. Iterating from the lowest
    // priority slot upward lets the highest priority match overwrite.
    always_comb begin
        w_grant = r_last;
        for (int k = 4; k >= 1; k--) begin
            if (in_valid[r_last + 2'(k)]) begin
                w_grant = r_last + 2'(k);
            end
        end
    end

    always_comb begin
        w_grant_data = a;
        case (w_grant)
            2'd0:    w_grant_data = a;
            2'd1:    w_grant_data = b;
            2'd2:    w_grant_data = c;
            default: w_grant_data = d;
        endcase
    end

    // One-hot accept strobe on the granted channel only.
    always_comb begin
        in_ready = 4'b0000;
        if (w_take) begin
            in_ready[w_grant] = 1'b1;
        end
    end

    // Output stage: a new word replaces the held one whenever the register
    // is empty or being drained this cycle, giving full throughput.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            out       <= '0;
            select    <= 2'd0;
            out_valid <= 1'b0;
            r_last    <= C_LAST_RESET;
        end else if (w_take) begin
            out       <= w_grant_data;
            select    <= w_grant;
            out_valid <= 1'b1;
            r_last    <= w_grant;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arbiter_4_way_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbiter_4_way_16
// Purpose  : Self-checking bench for arbiter_4_way_16. A reference model
//            predicts the grant for every cycle of stimulus and pushes the
//            expected word into a scoreboard queue; the held output is
//            compared against the queue head and popped on delivery.
// Revision : 1.0  initial release
// ============================================================================
module tb_arbiter_4_way_16;

    localparam int WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [1:0]       sel;
    } exp_t;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] a, b, c, d;
    logic [3:0]       in_valid;
    logic [3:0]       in_ready;
    logic [WIDTH-1:0] out;
    logic [1:0]       select;
    logic             out_valid;
    logic             out_ready;

    arbiter_4_way_16 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .select    (select),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    // Reference model state
    logic [1:0] m_last;
    logic       m_ov;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] chan_data(input logic [1:0] i);
        case (i)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return d;
        endcase
    endfunction

    // Drive one cycle of stimulus (called #1 after a rising edge), check at
    // the falling edge, then advance the model and the scoreboard.
    task automatic step(input logic [3:0] iv, input logic ordy);
        logic       load;
        logic       found;
        logic [1:0] g;
        logic [1:0] idx;
        logic [3:0] exp_rdy;
        exp_t       e;
        in_valid  = iv;
        out_ready = ordy;
        load  = !m_ov || ordy;
        found = 1'b0;
        g     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = m_last + 2'(k);
            if (!found && iv[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        exp_rdy = (load && found) ? (4'b0001 << g) : 4'b0000;
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            if (sb_q.size() == 0) begin
                check("scoreboard_empty", 32'(sb_q.size()), 32'd1);
            end else begin
                check("out", 32'(out), 32'(sb_q[0].data));
                check("select", 32'(select), 32'(sb_q[0].sel));
                if (ordy) void'(sb_q.pop_front());
            end
        end
        if (load && found) begin
            e.data = chan_data(g);
            e.sel  = g;
            sb_q.push_back(e);
            m_ov   = 1'b1;
            m_last = g;
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_last = 2'd3;
        m_ov   = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        a = 16'd1; b = 16'd2; c = 16'd3; d = 16'd4;
        model_reset();

        // Reset state, with requests present
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_select", 32'(select), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        reset_n  = 1'b1;
        in_valid = 4'b0000;
        repeat (3) @(posedge clk);
        #1;

        // All four channels request continuously: 1,2,3,4,1,2,3,4
        for (int i = 0; i < 8; i++) step(4'b1111, 1'b1);
        step(4'b0000, 1'b1);

        // Single requester on channel 2
        c = 16'hBEEF;
        step(4'b0100, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // Back-pressure for 5 cycles, then resume at last+1
        step(4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) step(4'b1111, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b1);
        step(4'b0000, 1'b1);

        // Wrap-around: grant 3, then 0 and 3 request -> 0 then 3
        step(4'b1000, 1'b1);
        step(4'b1001, 1'b1);
        step(4'b1001, 1'b1);
        step(4'b0000, 1'b1);

        // Random traffic and back-pressure
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            c = 16'($urandom); d = 16'($urandom);
            step(4'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        step(4'b0000, 1'b1);

        // Reset mid-transfer at a non-edge-aligned time
        step(4'b1111, 1'b0);
        in_valid = 4'b1010;
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out", 32'(out), 32'd0);
        check("midrst_select", 32'(select), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        #2;
        reset_n  = 1'b1;
        in_valid = 4'b0000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        step(4'b1010, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
